// File: rtl/mx_int8_bd_dequant_pkg.sv
// Shared constants and types for the MXINT8 block dequantizer.
`ifndef FLOAT32_WIDTH
`define FLOAT32_WIDTH 32
`endif

package mx_int8_bd_dequant_pkg;

  localparam int MXINT8_ELEM_WIDTH = 8;
  localparam int E8M0_WIDTH        = 8;
  localparam int E8M0_BIAS         = 127;
  localparam int MXINT8_FRAC_BITS  = 6;

  localparam logic [E8M0_WIDTH-1:0] E8M0_NAN     = 8'hFF;
  localparam logic [31:0]           FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0]           FP32_POS_INF = 32'h7F800000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/mx_int8_elem_to_fp32.sv
// Combinational conversion of one int8 element under an E8M0 scale into an
// exact float32: value = elem / 64 * 2^(scale - 127).
module mx_int8_elem_to_fp32
  import mx_int8_bd_dequant_pkg::*;
(
  input  logic [E8M0_WIDTH-1:0]        scale_i,
  input  logic [MXINT8_ELEM_WIDTH-1:0] elem_i,
  output logic [`FLOAT32_WIDTH-1:0]    fp32_o
);

  logic              sign;
  logic [7:0]        mag;
  logic [2:0]        lead_pos;
  logic signed [9:0] exp_s;
  logic [22:0]       mant_norm;
  logic [22:0]       mant_sub;

  always_comb begin
    sign = elem_i[7];
    // -128 negates back to 8'h80, which is the correct magnitude 128.
    mag  = sign ? (~elem_i + 8'd1) : elem_i;

    lead_pos = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) lead_pos = 3'(b);
    end

    exp_s = $signed({2'b00, scale_i}) + $signed({7'b0, lead_pos})
            - 10'(MXINT8_FRAC_BITS);

    // The 23-bit shift drops the implicit leading one off the top.
    mant_norm = {15'b0, mag} << (5'd23 - {2'b00, lead_pos});
    mant_sub  = {15'b0, mag} << ({1'b0, scale_i} + 9'd16);

    if (scale_i == E8M0_NAN) begin
      fp32_o = FP32_QNAN;
    end else if (elem_i == 8'd0) begin
      fp32_o = 32'h0000_0000;
    end else if (exp_s >= 10'sd255) begin
      fp32_o = FP32_POS_INF | {sign, 31'b0};
    end else if (exp_s >= 10'sd1) begin
      fp32_o = {sign, exp_s[7:0], mant_norm};
    end else begin
      fp32_o = {sign, 8'h00, mant_sub};
    end
  end

endmodule

// File: rtl/mx_int8_bd_dequant.sv
// MXINT8 block to float32 stream: latches one scale + K int8 elements and
// emits K float32 scalars in order, one per handshake, back-to-back capable.
module mx_int8_bd_dequant
  import mx_int8_bd_dequant_pkg::*;
#(
  parameter int K     = 32,
  parameter int IDX_W = $clog2(K)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [E8M0_WIDTH-1:0]                in_scale_i,
  input  logic [MXINT8_ELEM_WIDTH*K-1:0]       in_elem_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [`FLOAT32_WIDTH-1:0]            out_float32_o,
  output logic [IDX_W-1:0]                     out_idx_o,
  output logic                                 out_last_o
);

  state_e                         state_q, state_d;
  logic [E8M0_WIDTH-1:0]          scale_q, scale_d;
  logic [MXINT8_ELEM_WIDTH-1:0]   elem_q [K];
  logic [MXINT8_ELEM_WIDTH-1:0]   elem_d [K];
  logic [MXINT8_ELEM_WIDTH-1:0]   in_elem_arr [K];
  logic                           out_valid_q, out_valid_d;
  logic [`FLOAT32_WIDTH-1:0]      out_float_q, out_float_d;
  logic [IDX_W-1:0]               out_idx_q, out_idx_d;
  logic                           out_last_q, out_last_d;

  logic                           out_hs;
  logic                           last_hs;
  logic                           accept;
  logic [IDX_W-1:0]               idx_next;
  logic [E8M0_WIDTH-1:0]          conv_scale;
  logic [MXINT8_ELEM_WIDTH-1:0]   conv_elem;
  logic [`FLOAT32_WIDTH-1:0]      conv_fp32;

  for (genvar gi = 0; gi < K; gi++) begin : g_unpack
    assign in_elem_arr[gi] = in_elem_i[MXINT8_ELEM_WIDTH*gi +: MXINT8_ELEM_WIDTH];
  end

  assign out_hs     = out_valid_q && out_ready_i;
  assign last_hs    = out_hs && out_last_q;
  assign in_ready_o = !rst && ((state_q == ST_IDLE) || last_hs);
  assign accept     = in_valid_i && in_ready_o;
  assign idx_next   = out_idx_q + 1'b1;

  // A fresh block converts element 0 straight from the inputs so it shows up
  // the cycle after acceptance; otherwise convert the next latched element.
  assign conv_scale = accept ? in_scale_i     : scale_q;
  assign conv_elem  = accept ? in_elem_arr[0] : elem_q[idx_next];

  mx_int8_elem_to_fp32 u_conv (
    .scale_i (conv_scale),
    .elem_i  (conv_elem),
    .fp32_o  (conv_fp32)
  );

  always_comb begin
    state_d     = state_q;
    scale_d     = scale_q;
    elem_d      = elem_q;
    out_valid_d = out_valid_q;
    out_float_d = out_float_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;

    if (accept) begin
      state_d     = ST_EMIT;
      scale_d     = in_scale_i;
      elem_d      = in_elem_arr;
      out_valid_d = 1'b1;
      out_float_d = conv_fp32;
      out_idx_d   = '0;
      out_last_d  = (K == 1);
    end else if (last_hs) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (out_hs) begin
      out_float_d = conv_fp32;
      out_idx_d   = idx_next;
      out_last_d  = (idx_next == IDX_W'(K - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      scale_q     <= '0;
      out_valid_q <= 1'b0;
      out_float_q <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < K; i++) elem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      scale_q     <= scale_d;
      out_valid_q <= out_valid_d;
      out_float_q <= out_float_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < K; i++) elem_q[i] <= elem_d[i];
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_float32_o = out_float_q;
  assign out_idx_o     = out_idx_q;
  assign out_last_o    = out_last_q;

endmodule

// File: doc/mx_int8_bd_dequant.md
Name: mx_int8_bd_dequant

Overview:
- Decode direction of the MXINT8 block path: turns a quantized MXINT8 block back into a stream of float32 scalars.
- Input block: one shared E8M0 scale plus K int8 elements.
- Output: K IEEE-754 float32 values, one per cycle, in element order, under valid/ready.
- Sits after the fp32→MXINT8 quantizer. Used in hardware read-back paths and in closed-loop benches that compare dequantized output against the fp32 source.

Parameters:
- K, 32, elements per MX block (power of two, 2..64).
- IDX_W, $clog2(K), width of the element index.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid_i  input  1  block present on in_scale_i/in_elem_i.
- in_ready_o  output  1  block accepted when in_valid_i && in_ready_o.
- in_scale_i  input  8  shared E8M0 scale, bias 127; 0xFF = NaN.
- in_elem_i  input  8*K  K two's-complement int8 elements; element i at [8i+7:8i].
- out_valid_o  output  1  out_float32_o valid.
- out_ready_i  input  1  consumer accepts this cycle.
- out_float32_o  output  `FLOAT32_WIDTH  dequantized scalar.
- out_idx_o  output  IDX_W  element index of the current output.
- out_last_o  output  1  high with element K-1.

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid_o=0, out_float32_o=0, out_idx_o=0, out_last_o=0, FSM=IDLE.
  - in_ready_o forced 0 while rst=1.
  - Any in-flight block is discarded; no partial output after reset.
- FSM:
  - IDLE: in_ready_o=1. On accept, latch scale and all K elements into block regs, go to EMIT.
  - EMIT: out_valid_o=1. Each out handshake advances idx.
  - After the handshake with idx=K-1: go to IDLE, or stay in EMIT if a new block is accepted the same cycle.
- in_ready_o = (state==IDLE) || (out_valid_o && out_ready_i && out_last_o), gated by !rst. This combinational path from out_ready_i is intended and gives back-to-back blocks.
- Latency and throughput:
  - Block accepted at edge t → element 0 on outputs after edge t (registered).
  - With out_ready_i held high: one element per cycle, K cycles per block, zero bubbles between blocks.
- Backpressure: while out_valid_o && !out_ready_i, all out_* outputs are held stable.
- Element conversion, exact with no rounding. Element value = elem/64 × 2^(scale−127).
  - scale==0xFF → 0x7FC00000 for every element, regardless of elem.
  - elem==0 → 0x00000000 (+0).
  - Otherwise: sign = elem[7]; mag = |elem| (1..128; −128 → mag 128, no overflow, 8-bit magnitude via 9-bit negate); p = leading-one position of mag (0..7); e = scale + p − 6 (signed, 10 bits).
  - e ≥ 255 → ±Inf (0x7F800000 | sign<<31). Only reachable with scale=254 and elem=−128.
  - 1 ≤ e ≤ 254 → normal: exponent = e, mantissa = mag bits below the leading one, left-aligned in 23 bits.
  - e ≤ 0 → subnormal: exponent 0, mantissa = mag << (scale+16). Always fits in 23 bits; no precision loss.
- Scale changes only at block boundaries; the latched scale applies to all K elements.
- in_scale_i/in_elem_i are ignored when no handshake occurs.

Decomposition:
- Shared include (alongside the existing scalar/mxint8 includes):
  - MXINT8_ELEM_WIDTH=8, E8M0_WIDTH=8, E8M0_BIAS=127, E8M0_NAN=8'hFF.
  - MXINT8_FRAC_BITS=6.
  - FP32_QNAN=32'h7FC00000, FP32_POS_INF=32'h7F800000.
  - `FLOAT32_WIDTH (already defined).
- Sub-module mx_int8_elem_to_fp32: purely combinational (scale, elem) → float32. Reused by the bench scoreboard as the golden model.
- Top level holds the FSM, block register, index counter and output register.

Test Plan:
- Nominal values: scale=0x7F, elems[0..3]={64,−128,1,0} → 0x3F800000, 0xC0000000, 0x3C800000, 0x00000000; idx 0..3; out_last_o only at idx K−1.
- NaN scale: scale=0xFF, random elems → all K outputs 0x7FC00000.
- Top of range: scale=0xFE, elem=127 → 0x7F7E0000; elem=−128 → 0xFF800000 (−Inf).
- Subnormals: scale=0x00, elem=1 → 0x00010000; elem=−64 → 0x80400000; scale=0x06, elem=1 → 0x00400000.
- Handshake:
  - Drop out_ready_i for 5 cycles at idx 3 → out_float32_o/out_idx_o stable.
  - Second block held on in_valid_i during block 1 → accepted in the same cycle as block 1's last handshake; block 2 idx 0 follows next cycle, no bubble.
- Reset mid-block: assert rst at idx 10 → next cycle out_valid_o=0, in_ready_o=1 after release; the next block starts at idx 0 with none of the old data.
